mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

MEM-stage data-memory sequencer for the pipelined LC-3b datapath. It consumes the memory fields of the control word produced by decode (`mem_read`, `mem_write`, `indirect_enable`, `mem_byte_enable`, `opcode`, `is_nop`), together with the EX-stage address and store data. It runs the one- or two-phase data-memory handshake and stalls the pipeline until the load data, or the store completion, is ready. LDI/STI pointer dereference is handled entirely inside this block.

## Interface
No parameters.
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid  in  1  MEM-stage instruction valid (`~is_nop`)
- opcode  in  4  lc3b_opcode of the MEM-stage instruction
- mem_read  in  1  control word: instruction reads memory
- mem_write  in  1  control word: instruction writes memory
- indirect_enable  in  1  control word: LDI/STI pointer phase required
- mem_byte_enable  in  2  control word byte enables for non-indirect access
- address  in  16  EX-computed effective address
- wdata  in  16  store data (already byte-replicated for STB)
- dmem_resp  in  1  data memory completion pulse
- dmem_rdata  in  16  data memory read data, valid with dmem_resp
- dmem_read  out  1  memory read request, registered
- dmem_write  out  1  memory write request, registered
- dmem_address  out  16  request address, registered
- dmem_byte_enable  out  2  request byte enables, registered
- dmem_wdata  out  16  request write data, registered
- rdata  out  16  load result to writeback, registered
- rdata_valid  out  1  high in DONE for load instructions
- stall  out  1  combinational; freeze IF/ID/EX/MEM registers

## Operation
- States: IDLE, IND (pointer read), ACC (final access), DONE.
- start = valid & (mem_read | mem_write).
- Inputs are sampled only on the IDLE->IND/ACC edge and latched into internal registers (address, wdata, byte enables, direction). Later input changes are ignored until return to IDLE.
- IDLE, start & indirect_enable -> IND. The block drives dmem_read=1 with address and byte_enable=2'b11.
- IDLE, start & ~indirect_enable -> ACC:
  - dmem_read = mem_read & ~mem_write
  - dmem_write = mem_write
  - byte_enable = mem_byte_enable
- IND, dmem_resp -> ACC:
  - latched address <= dmem_rdata, byte_enable = 2'b11
  - direction is write iff opcode == op_sti, else read (LDI)
  - dmem_write takes that direction; wdata is the latched store data.
- ACC, dmem_resp -> DONE. On a read, rdata <= dmem_rdata; on a write, rdata is unchanged.
- DONE -> IDLE unconditionally. rdata_valid=1 iff the final access was a read.
- Request outputs (dmem_read/dmem_write) stay asserted, and address/data stay stable, for every cycle in IND/ACC until dmem_resp. They are 0 in IDLE and DONE.
- stall = rst_n & ((IDLE & start) | IND | ACC). stall=0 in DONE, so the instruction retires from MEM at the end of DONE. DONE never restarts the same instruction.
- valid=0, or neither read nor write: IDLE holds and stall=0 (ALU/branch ops pass through with zero added latency).
- dmem_resp in IDLE or DONE is ignored.
- Flushes do not abort an in-flight access. Upstream flush produces valid=0, which only affects IDLE sampling.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE; dmem_read=0, dmem_write=0, dmem_address=0, dmem_byte_enable=2'b00, dmem_wdata=0, rdata=0, rdata_valid=0, stall=0.
- Reset mid-operation: the request drops immediately and nothing is latched. After release the block samples inputs fresh in IDLE.
- Non-indirect access, memory latency L cycles (resp in the L-th ACC cycle, L>=1): the instruction occupies MEM for L+2 cycles (IDLE 1, ACC L, DONE 1).
- Indirect access with pointer latency L1 and data latency L2: L1+L2+2 cycles.
- dmem_resp and rst_n deassertion on the same edge: reset wins.
- Back-to-back memory ops: the second instruction enters MEM after DONE and is sampled in IDLE on its first cycle. Minimum spacing is L+2 cycles.

## Test plan
- LDR to 0x3000 with mem_byte_enable=11, resp after 1 cycle with 0xBEEF -> dmem_read high 1 cycle at 0x3000; stall high 2 cycles; rdata=0xBEEF with rdata_valid in cycle 3.
- STB to 0x3001 with byte_enable=10, wdata=0xAB00, resp after 3 cycles -> dmem_write held 3 cycles with stable address/data/BE=10; rdata_valid=0 in DONE; stall low in DONE.
- LDI at 0x4000, pointer 0x5000, data 0x1234 -> read 0x4000 BE=11, then read 0x5000 BE=11; rdata=0x1234; stall high for 3 cycles with unit latency.
- STI at 0x4000, pointer 0x6002, wdata 0x0F0F -> read 0x4000, then write 0x6002 data 0x0F0F BE=11; no rdata_valid.
- ADD (valid, no mem) and a nop with mem_read=1 but valid=0 -> stall=0, no dmem request, state stays IDLE.
- rst_n pulsed low during an ACC wait, plus a spurious dmem_resp in IDLE -> all outputs at reset values immediately, no state change on the stray resp.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory sequencer: runs the one- or two-phase (LDI/STI pointer)
// data-memory handshake and stalls the pipeline until the access completes.
module mem_access_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [3:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        indirect_enable,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_wdata,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        stall
);

    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IND  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        read_reg, read_next;
    logic        write_reg, write_next;
    logic [15:0] address_reg, address_next;
    logic [1:0]  be_reg, be_next;
    logic [15:0] wdata_reg, wdata_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        sti_reg, sti_next;
    logic        done_read_reg, done_read_next;
    logic        start;

    assign start = valid & (mem_read | mem_write);

    // State and datapath registers; the request outputs are driven straight from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            read_reg      <= 1'b0;
            write_reg     <= 1'b0;
            address_reg   <= 16'h0000;
            be_reg        <= 2'b00;
            wdata_reg     <= 16'h0000;
            rdata_reg     <= 16'h0000;
            sti_reg       <= 1'b0;
            done_read_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            read_reg      <= read_next;
            write_reg     <= write_next;
            address_reg   <= address_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            sti_reg       <= sti_next;
            done_read_reg <= done_read_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = indirect_enable ? ST_IND : ST_ACC;
                end
            end
            ST_IND: begin
                if (dmem_resp) begin
                    state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                if (dmem_resp) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        read_next      = read_reg;
        write_next     = write_reg;
        address_next   = address_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        sti_next       = sti_reg;
        done_read_next = done_read_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    address_next = address;
                    wdata_next   = wdata;
                    sti_next     = (opcode == OP_STI);
                    if (indirect_enable) begin
                        // Pointer fetch is always a full-word read.
                        read_next  = 1'b1;
                        write_next = 1'b0;
                        be_next    = 2'b11;
                    end else begin
                        read_next  = mem_read & ~mem_write;
                        write_next = mem_write;
                        be_next    = mem_byte_enable;
                    end
                end
            end
            ST_IND: begin
                if (dmem_resp) begin
                    address_next = dmem_rdata;
                    be_next      = 2'b11;
                    read_next    = ~sti_reg;
                    write_next   = sti_reg;
                end
            end
            ST_ACC: begin
                if (dmem_resp) begin
                    read_next      = 1'b0;
                    write_next     = 1'b0;
                    done_read_next = read_reg;
                    if (read_reg) begin
                        rdata_next = dmem_rdata;
                    end
                end
            end
            default: begin
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase
    end

    // Stall only while an access is pending; DONE lets the instruction retire.
    always_comb begin
        stall       = 1'b0;
        rdata_valid = 1'b0;
        case (state_reg)
            ST_IDLE: stall = rst_n & start;
            ST_IND:  stall = rst_n;
            ST_ACC:  stall = rst_n;
            default: rdata_valid = done_read_reg;
        endcase
    end

    assign dmem_read        = read_reg;
    assign dmem_write       = write_reg;
    assign dmem_address     = address_reg;
    assign dmem_byte_enable = be_reg;
    assign dmem_wdata       = wdata_reg;
    assign rdata            = rdata_reg;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: LDR, STB, LDI, STI, non-memory ops,
// and reset behaviour, with hand-computed expectations.
module tb_mem_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [3:0]  opcode;
    logic        mem_read;
    logic        mem_write;
    logic        indirect_enable;
    logic [1:0]  mem_byte_enable;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_wdata;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        stall;

    int errors = 0;
    int checks = 0;

    mem_access_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid            (valid),
        .opcode           (opcode),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .indirect_enable  (indirect_enable),
        .mem_byte_enable  (mem_byte_enable),
        .address          (address),
        .wdata            (wdata),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .rdata            (rdata),
        .rdata_valid      (rdata_valid),
        .stall            (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] op, input logic rd, input logic wr,
                         input logic ind, input logic [1:0] be, input logic [15:0] a,
                         input logic [15:0] d);
        valid = v; opcode = op; mem_read = rd; mem_write = wr;
        indirect_enable = ind; mem_byte_enable = be; address = a; wdata = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, rdata, rdata_valid, stall} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b a=%h be=%b wd=%h rdata=%h rv=%b st=%b required all zero",
                     dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, rdata, rdata_valid, stall);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs at reset values");
    endtask

    task automatic test_ldr;
        drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 2'b11, 16'h3000, 16'h0);
        #1;
        checks++;
        if (stall !== 1'b1 || dmem_read !== 1'b0) begin
            errors++;
            $display("FAIL ldr_idle: got stall=%b rd=%b required stall=1 rd=0", stall, dmem_read);
        end
        @(negedge clk);
        checks++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 16'h3000 || dmem_byte_enable !== 2'b11 || stall !== 1'b1) begin
            errors++;
            $display("FAIL ldr_acc: got rd=%b wr=%b a=%h be=%b st=%b required 1 0 3000 11 1",
                     dmem_read, dmem_write, dmem_address, dmem_byte_enable, stall);
        end
        dmem_resp = 1'b1; dmem_rdata = 16'hBEEF;
        @(negedge clk);
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        valid = 1'b0;
        #1;
        checks++;
        if (rdata !== 16'hBEEF || rdata_valid !== 1'b1 || stall !== 1'b0 || dmem_read !== 1'b0) begin
            errors++;
            $display("FAIL ldr_done: got rdata=%h rv=%b st=%b rd=%b required beef 1 0 0", rdata, rdata_valid, stall, dmem_read);
        end
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b0 || stall !== 1'b0 || dmem_read !== 1'b0) begin
            errors++;
            $display("FAIL ldr_retire: got rv=%b st=%b rd=%b required 0 0 0", rdata_valid, stall, dmem_read);
        end
        $display("ldr: 0x3000 -> rdata=%h", rdata);
    endtask

    task automatic test_stb;
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 2'b10, 16'h3001, 16'hAB00);
        @(negedge clk);
        // Upstream inputs change while the access is in flight; they must be ignored.
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 2'b01, 16'hFFFF, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_address !== 16'h3001 ||
                dmem_wdata !== 16'hAB00 || dmem_byte_enable !== 2'b10 || stall !== 1'b1) begin
                errors++;
                $display("FAIL stb_acc%0d: got wr=%b rd=%b a=%h wd=%h be=%b st=%b required 1 0 3001 ab00 10 1",
                         i, dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable, stall);
            end
            if (i == 2) dmem_resp = 1'b1;
            @(negedge clk);
        end
        dmem_resp = 1'b0;
        valid = 1'b0;
        #1;
        checks++;
        if (rdata_valid !== 1'b0 || stall !== 1'b0 || dmem_write !== 1'b0 || rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL stb_done: got rv=%b st=%b wr=%b rdata=%h required 0 0 0 beef", rdata_valid, stall, dmem_write, rdata);
        end
        @(negedge clk);
        $display("stb: 0x3001 <- ab00 be=10");
    endtask

    task automatic test_ldi;
        drive(1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 2'b01, 16'h4000, 16'h0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL ldi_idle_stall: got %b required 1", stall);
        end
        @(negedge clk);
        checks++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 16'h4000 || dmem_byte_enable !== 2'b11 || stall !== 1'b1) begin
            errors++;
            $display("FAIL ldi_ind: got rd=%b wr=%b a=%h be=%b st=%b required 1 0 4000 11 1",
                     dmem_read, dmem_write, dmem_address, dmem_byte_enable, stall);
        end
        dmem_resp = 1'b1; dmem_rdata = 16'h5000;
        @(negedge clk);
        checks++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 16'h5000 || dmem_byte_enable !== 2'b11 || stall !== 1'b1) begin
            errors++;
            $display("FAIL ldi_acc: got rd=%b wr=%b a=%h be=%b st=%b required 1 0 5000 11 1",
                     dmem_read, dmem_write, dmem_address, dmem_byte_enable, stall);
        end
        dmem_rdata = 16'h1234;
        @(negedge clk);
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        valid = 1'b0;
        #1;
        checks++;
        if (rdata !== 16'h1234 || rdata_valid !== 1'b1 || stall !== 1'b0 || dmem_read !== 1'b0) begin
            errors++;
            $display("FAIL ldi_done: got rdata=%h rv=%b st=%b rd=%b required 1234 1 0 0", rdata, rdata_valid, stall, dmem_read);
        end
        @(negedge clk);
        $display("ldi: [0x4000]=5000 -> rdata=%h", rdata);
    endtask

    task automatic test_sti;
        drive(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 2'b01, 16'h4000, 16'h0F0F);
        @(negedge clk);
        checks++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 16'h4000 || dmem_byte_enable !== 2'b11) begin
            errors++;
            $display("FAIL sti_ind: got rd=%b wr=%b a=%h be=%b required 1 0 4000 11",
                     dmem_read, dmem_write, dmem_address, dmem_byte_enable);
        end
        dmem_resp = 1'b1; dmem_rdata = 16'h6002;
        @(negedge clk);
        dmem_rdata = 16'h0;
        checks++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b1 || dmem_address !== 16'h6002 ||
            dmem_wdata !== 16'h0F0F || dmem_byte_enable !== 2'b11 || stall !== 1'b1) begin
            errors++;
            $display("FAIL sti_acc: got rd=%b wr=%b a=%h wd=%h be=%b st=%b required 0 1 6002 0f0f 11 1",
                     dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, stall);
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        valid = 1'b0;
        #1;
        checks++;
        if (rdata_valid !== 1'b0 || stall !== 1'b0 || dmem_write !== 1'b0 || rdata !== 16'h1234) begin
            errors++;
            $display("FAIL sti_done: got rv=%b st=%b wr=%b rdata=%h required 0 0 0 1234", rdata_valid, stall, dmem_write, rdata);
        end
        @(negedge clk);
        $display("sti: [0x4000]=6002 <- 0f0f");
    endtask

    task automatic test_no_mem;
        drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b11, 16'h1111, 16'h2222);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
                errors++;
                $display("FAIL add_pass%0d: got st=%b rd=%b wr=%b required 0 0 0", i, stall, dmem_read, dmem_write);
            end
            @(negedge clk);
        end
        drive(1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 2'b11, 16'h3000, 16'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
                errors++;
                $display("FAIL nop_pass%0d: got st=%b rd=%b wr=%b required 0 0 0", i, stall, dmem_read, dmem_write);
            end
            @(negedge clk);
        end
        $display("no_mem: add and nop pass with no stall");
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 2'b11, 16'h7000, 16'h0);
        @(negedge clk);
        checks++;
        if (dmem_read !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_acc: got rd=%b st=%b required 1 1", dmem_read, stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, rdata, rdata_valid, stall} !== 53'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rd=%b wr=%b a=%h be=%b wd=%h rdata=%h rv=%b st=%b required all zero",
                     dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata, rdata, rdata_valid, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || rdata !== 16'h0000 || rdata_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp: got rd=%b wr=%b rdata=%h rv=%b st=%b required 0 0 0000 0 0",
                     dmem_read, dmem_write, rdata, rdata_valid, stall);
        end
        // A fresh load after reset must start from IDLE with unit latency.
        drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0042, 16'h0);
        @(negedge clk);
        checks++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h0042) begin
            errors++;
            $display("FAIL post_reset_load: got rd=%b a=%h required 1 0042", dmem_read, dmem_address);
        end
        dmem_resp = 1'b1; dmem_rdata = 16'hCAFE;
        @(negedge clk);
        dmem_resp = 1'b0;
        valid = 1'b0;
        #1;
        checks++;
        if (rdata !== 16'hCAFE || rdata_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done: got rdata=%h rv=%b required cafe 1", rdata, rdata_valid);
        end
        @(negedge clk);
        $display("reset_mid: request dropped, stray resp ignored, reload rdata=%h", rdata);
    endtask

    initial begin
        test_reset;
        test_ldr;
        test_stb;
        test_ldi;
        test_sti;
        test_no_mem;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
